// File: rtl/kernel_buffer_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : kernel_buffer_ctrl_pkg
// Purpose  : Shared constants for the kernel buffer controller: default
//            geometry, write FSM state encoding and a small index helper.
// Revision : 1.0 - initial release
// ============================================================================
package kernel_buffer_ctrl_pkg;

  // Default geometry
  localparam int DEF_DATA_W    = 16;
  localparam int DEF_ADDR_W    = 9;
  localparam int DEF_NUM_BANKS = 2;

  // Write FSM state encoding
  localparam int         WR_ST_W      = 2;
  localparam logic [1:0] WR_IDLE      = 2'd0;
  localparam logic [1:0] WR_WAIT_BANK = 2'd1;
  localparam logic [1:0] WR_LOAD      = 2'd2;

  // True when cnt addresses the last entry of a block holding size entries.
  // A zero size never matches, so an empty block can never complete.
  function automatic logic is_final_idx(input int unsigned cnt,
                                        input int unsigned size);
    return (size != 0) && (cnt == size - 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/kernel_rd_addr_gen.sv
`default_nettype none
// ============================================================================
// Module   : kernel_rd_addr_gen
// Purpose  : Read-side address generator. Walks the channels of the bank
//            currently being consumed, remembers the kernel size committed
//            for each bank, and releases a bank after its last channel.
// Revision : 1.0 - initial release
// ============================================================================
module kernel_rd_addr_gen
  import kernel_buffer_ctrl_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int NUM_BANKS = DEF_NUM_BANKS,
  parameter int BANK_W    = $clog2(NUM_BANKS)
) (
  input  logic                     clk,
  input  logic                     Reset,
  input  logic                     rd_advance_i,
  input  logic [NUM_BANKS-1:0]     bank_full_i,
  input  logic                     commit_i,
  input  logic [BANK_W-1:0]        commit_bank_i,
  input  logic [ADDR_W:0]          commit_size_i,
  output logic [BANK_W+ADDR_W-1:0] rd_addr_o,
  output logic [BANK_W-1:0]        rd_bank_o,
  output logic                     release_o,
  output logic                     underflow_o
);

  logic [ADDR_W-1:0] rd_cnt_q, rd_cnt_d;
  logic [BANK_W-1:0] rd_bank_q, rd_bank_d;
  logic              underflow_q;
  logic [ADDR_W:0]   w_sizes [NUM_BANKS];
  logic [ADDR_W:0]   w_size_rd;
  logic              w_rd_ok;
  logic              w_rd_last;

  // One size register per bank, loaded when a write into that bank completes
  // so that an abandoned partial load never disturbs the stored size.
  generate
    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank_size
      logic [ADDR_W:0] size_q;

      // Capture the committed size for this bank
      always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
          size_q <= '0;
        end else if (commit_i && (commit_bank_i == BANK_W'(b))) begin
          size_q <= commit_size_i;
        end
      end

      assign w_sizes[b] = size_q;
    end
  endgenerate

  assign w_size_rd = w_sizes[rd_bank_q];
  assign w_rd_ok   = rd_advance_i && bank_full_i[rd_bank_q];
  assign w_rd_last = w_rd_ok && is_final_idx(32'(rd_cnt_q), 32'(w_size_rd));

  // Next read position: step within the bank, wrap to the next bank at the end
  always_comb begin
    rd_cnt_d  = rd_cnt_q;
    rd_bank_d = rd_bank_q;
    if (w_rd_ok) begin
      if (w_rd_last) begin
        rd_cnt_d  = '0;
        rd_bank_d = rd_bank_q + BANK_W'(1);
      end else begin
        rd_cnt_d  = rd_cnt_q + ADDR_W'(1);
      end
    end
  end

  // Read position registers and the registered underflow pulse
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      rd_cnt_q    <= '0;
      rd_bank_q   <= '0;
      underflow_q <= 1'b0;
    end else begin
      rd_cnt_q    <= rd_cnt_d;
      rd_bank_q   <= rd_bank_d;
      underflow_q <= rd_advance_i && !bank_full_i[rd_bank_q];
    end
  end

  assign rd_addr_o   = {rd_bank_q, rd_cnt_q};
  assign rd_bank_o   = rd_bank_q;
  assign release_o   = w_rd_last;
  assign underflow_o = underflow_q;

endmodule
`default_nettype wire

// File: rtl/kernel_buffer_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : kernel_buffer_ctrl
// Purpose  : Multi-bank kernel buffer controller. Loads kernels from an
//            AXI-Stream into BRAM banks (write port A) and hands completed
//            banks to a channel-stepping reader (read port B), ping-ponging
//            between banks so loading and consuming can overlap.
// Revision : 1.0 - initial release
// ============================================================================
module kernel_buffer_ctrl
  import kernel_buffer_ctrl_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int NUM_BANKS = DEF_NUM_BANKS
) (
  input  logic                                clk,
  input  logic                                Reset,
  input  logic [ADDR_W:0]                     cfg_channel_size,
  input  logic                                load_req,
  input  logic [DATA_W-1:0]                   s_axis_tdata,
  input  logic                                s_axis_tvalid,
  input  logic                                s_axis_tlast,
  output logic                                s_axis_tready,
  output logic                                bram_a_en,
  output logic                                bram_a_we,
  output logic [$clog2(NUM_BANKS)+ADDR_W-1:0] bram_a_addr,
  output logic [DATA_W-1:0]                   bram_a_din,
  input  logic                                rd_advance,
  output logic                                bram_b_en,
  output logic [$clog2(NUM_BANKS)+ADDR_W-1:0] bram_b_addr,
  output logic                                load_done,
  output logic                                last_channel,
  output logic                                rd_underflow,
  output logic [NUM_BANKS-1:0]                bank_full,
  output logic                                tlast_err,
  output logic                                cfg_err,
  output logic                                busy
);

  localparam int BANK_W = $clog2(NUM_BANKS);

  logic [WR_ST_W-1:0]   state_q, state_d;
  logic [ADDR_W-1:0]    wr_cnt_q, wr_cnt_d;
  logic [BANK_W-1:0]    wr_bank_q, wr_bank_d;
  logic [ADDR_W:0]      size_q, size_d;
  logic [NUM_BANKS-1:0] bank_full_q, bank_full_d;
  logic                 tlast_err_q, tlast_err_d;
  logic                 cfg_err_q, cfg_err_d;
  logic                 load_done_q, load_done_d;

  logic                 w_beat;
  logic                 w_final_idx;
  logic                 w_final_beat;
  logic [NUM_BANKS-1:0] w_set_mask;
  logic [NUM_BANKS-1:0] w_clr_mask;
  logic                 w_rd_release;
  logic [BANK_W-1:0]    w_rd_bank;

  assign w_beat       = (state_q == WR_LOAD) && s_axis_tvalid;
  assign w_final_idx  = is_final_idx(32'(wr_cnt_q), 32'(size_q));
  assign w_final_beat = w_beat && w_final_idx;

  // Write FSM: accept a load, wait for the target bank to drain, stream beats
  always_comb begin
    state_d     = state_q;
    wr_cnt_d    = wr_cnt_q;
    wr_bank_d   = wr_bank_q;
    size_d      = size_q;
    tlast_err_d = tlast_err_q;
    cfg_err_d   = cfg_err_q;
    load_done_d = 1'b0;
    case (state_q)
      WR_IDLE: begin
        if (load_req) begin
          // Error flags describe the most recent request only
          tlast_err_d = 1'b0;
          cfg_err_d   = 1'b0;
          if (cfg_channel_size == '0) begin
            cfg_err_d = 1'b1;
          end else begin
            size_d   = cfg_channel_size;
            wr_cnt_d = '0;
            state_d  = bank_full_q[wr_bank_q] ? WR_WAIT_BANK : WR_LOAD;
          end
        end
      end
      WR_WAIT_BANK: begin
        if (!bank_full_q[wr_bank_q]) begin
          state_d = WR_LOAD;
        end
      end
      WR_LOAD: begin
        if (w_beat) begin
          // tlast is advisory: a mismatch is flagged but never shortens
          // or extends the load, which always ends after size beats
          if (s_axis_tlast != w_final_idx) begin
            tlast_err_d = 1'b1;
          end
          if (w_final_idx) begin
            wr_cnt_d    = '0;
            wr_bank_d   = wr_bank_q + BANK_W'(1);
            load_done_d = 1'b1;
            state_d     = WR_IDLE;
          end else begin
            wr_cnt_d    = wr_cnt_q + ADDR_W'(1);
          end
        end
      end
      default: begin
        state_d = WR_IDLE;
      end
    endcase
  end

  // Bank ownership: only a completed write sets a bit, only a final read
  // clears one; both may happen in one cycle on different banks
  assign w_set_mask  = w_final_beat ? (NUM_BANKS'(1) << wr_bank_q) : '0;
  assign w_clr_mask  = w_rd_release ? (NUM_BANKS'(1) << w_rd_bank) : '0;
  assign bank_full_d = (bank_full_q & ~w_clr_mask) | w_set_mask;

  // Write-side state registers; reset abandons any load in progress
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= WR_IDLE;
      wr_cnt_q    <= '0;
      wr_bank_q   <= '0;
      size_q      <= '0;
      bank_full_q <= '0;
      tlast_err_q <= 1'b0;
      cfg_err_q   <= 1'b0;
      load_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_cnt_q    <= wr_cnt_d;
      wr_bank_q   <= wr_bank_d;
      size_q      <= size_d;
      bank_full_q <= bank_full_d;
      tlast_err_q <= tlast_err_d;
      cfg_err_q   <= cfg_err_d;
      load_done_q <= load_done_d;
    end
  end

  kernel_rd_addr_gen #(
    .ADDR_W    (ADDR_W),
    .NUM_BANKS (NUM_BANKS),
    .BANK_W    (BANK_W)
  ) u_rd_addr_gen (
    .clk           (clk),
    .Reset         (Reset),
    .rd_advance_i  (rd_advance),
    .bank_full_i   (bank_full_q),
    .commit_i      (w_final_beat),
    .commit_bank_i (wr_bank_q),
    .commit_size_i (size_q),
    .rd_addr_o     (bram_b_addr),
    .rd_bank_o     (w_rd_bank),
    .release_o     (w_rd_release),
    .underflow_o   (rd_underflow)
  );

  assign s_axis_tready = (state_q == WR_LOAD);
  assign bram_a_en     = w_beat;
  assign bram_a_we     = w_beat;
  assign bram_a_addr   = {wr_bank_q, wr_cnt_q};
  assign bram_a_din    = s_axis_tdata;
  assign bram_b_en     = 1'b1;
  assign load_done     = load_done_q;
  assign last_channel  = w_rd_release;
  assign bank_full     = bank_full_q;
  assign tlast_err     = tlast_err_q;
  assign cfg_err       = cfg_err_q;
  assign busy          = (state_q != WR_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_kernel_buffer_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_kernel_buffer_ctrl
// Purpose  : Directed self-checking bench for kernel_buffer_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_kernel_buffer_ctrl;

  localparam int DATA_W    = 16;
  localparam int ADDR_W    = 9;
  localparam int NUM_BANKS = 2;
  localparam int AW        = 10;

  logic              clk = 1'b0;
  logic              Reset;
  logic [ADDR_W:0]   cfg_channel_size;
  logic              load_req;
  logic [DATA_W-1:0] s_axis_tdata;
  logic              s_axis_tvalid;
  logic              s_axis_tlast;
  logic              s_axis_tready;
  logic              bram_a_en;
  logic              bram_a_we;
  logic [AW-1:0]     bram_a_addr;
  logic [DATA_W-1:0] bram_a_din;
  logic              rd_advance;
  logic              bram_b_en;
  logic [AW-1:0]     bram_b_addr;
  logic              load_done;
  logic              last_channel;
  logic              rd_underflow;
  logic [1:0]        bank_full;
  logic              tlast_err;
  logic              cfg_err;
  logic              busy;

  int total = 0;
  int bad   = 0;

  logic [AW-1:0]     wq_addr [$];
  logic [DATA_W-1:0] wq_data [$];

  always #5 clk = ~clk;

  kernel_buffer_ctrl #(
    .DATA_W    (DATA_W),
    .ADDR_W    (ADDR_W),
    .NUM_BANKS (NUM_BANKS)
  ) dut (
    .clk              (clk),
    .Reset            (Reset),
    .cfg_channel_size (cfg_channel_size),
    .load_req         (load_req),
    .s_axis_tdata     (s_axis_tdata),
    .s_axis_tvalid    (s_axis_tvalid),
    .s_axis_tlast     (s_axis_tlast),
    .s_axis_tready    (s_axis_tready),
    .bram_a_en        (bram_a_en),
    .bram_a_we        (bram_a_we),
    .bram_a_addr      (bram_a_addr),
    .bram_a_din       (bram_a_din),
    .rd_advance       (rd_advance),
    .bram_b_en        (bram_b_en),
    .bram_b_addr      (bram_b_addr),
    .load_done        (load_done),
    .last_channel     (last_channel),
    .rd_underflow     (rd_underflow),
    .bank_full        (bank_full),
    .tlast_err        (tlast_err),
    .cfg_err          (cfg_err),
    .busy             (busy)
  );

  // Record every write strobe mid-cycle, away from the active edge
  always @(negedge clk) begin
    if (bram_a_en && bram_a_we) begin
      wq_addr.push_back(bram_a_addr);
      wq_data.push_back(bram_a_din);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    Reset = 1'b1;
    load_req = 1'b0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    rd_advance = 1'b0; cfg_channel_size = '0; s_axis_tdata = '0;
    step(); step();
    Reset = 1'b0;
    step();
    wq_addr.delete(); wq_data.delete();
  endtask

  task automatic issue_load(input int size);
    cfg_channel_size = (ADDR_W+1)'(size);
    load_req = 1'b1;
    step();
    load_req = 1'b0;
  endtask

  // n beats, tlast on index tl (-1 = never), optional idle cycle after each
  task automatic send_beats(input int n, input int tl, input bit gap, input logic [15:0] base);
    for (int i = 0; i < n; i++) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = base + 16'(i);
      s_axis_tlast  = (i == tl);
      step();
      if (gap) begin
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        step();
      end
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    load_req = 1'b0; s_axis_tvalid = 1'b1; s_axis_tlast = 1'b0;
    rd_advance = 1'b1; cfg_channel_size = 10'd4; s_axis_tdata = 16'h1234;
    step(); step();
    total++; if (s_axis_tready !== 1'b0) begin bad++; $display("FAIL reset_tready got=%b want=0", s_axis_tready); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (bram_a_en !== 1'b0 || bram_a_we !== 1'b0) begin bad++; $display("FAIL reset_a_en_we got=%b%b want=00", bram_a_en, bram_a_we); end
    total++; if (bank_full !== 2'b00) begin bad++; $display("FAIL reset_bank_full got=%b want=00", bank_full); end
    total++; if ({load_done, last_channel, rd_underflow, tlast_err, cfg_err} !== 5'b0) begin bad++;
      $display("FAIL reset_pulses_flags got=%b want=00000", {load_done, last_channel, rd_underflow, tlast_err, cfg_err}); end
    total++; if (bram_b_addr !== 10'd0 || bram_b_en !== 1'b1) begin bad++; $display("FAIL reset_b_port got=%0d/%b want=0/1", bram_b_addr, bram_b_en); end
    apply_reset();
  endtask

  task automatic test_clean_load();
    apply_reset();
    issue_load(9);
    total++; if (s_axis_tready !== 1'b1) begin bad++; $display("FAIL clean_tready_load got=%b want=1", s_axis_tready); end
    send_beats(9, 8, 1'b0, 16'hA000);
    total++; if (load_done !== 1'b1) begin bad++; $display("FAIL clean_load_done got=%b want=1", load_done); end
    total++; if (bank_full !== 2'b01) begin bad++; $display("FAIL clean_bank_full got=%b want=01", bank_full); end
    total++; if (s_axis_tready !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL clean_idle got=%b%b want=00", s_axis_tready, busy); end
    total++; if (tlast_err !== 1'b0) begin bad++; $display("FAIL clean_tlast_err got=%b want=0", tlast_err); end
    total++; if (wq_addr.size() != 9) begin bad++; $display("FAIL clean_write_count got=%0d want=9", wq_addr.size()); end
    for (int i = 0; i < 9 && i < wq_addr.size(); i++) begin
      total++; if (wq_addr[i] !== 10'(i) || wq_data[i] !== 16'hA000 + 16'(i)) begin bad++;
        $display("FAIL clean_write[%0d] got=%0d/%h want=%0d/%h", i, wq_addr[i], wq_data[i], i, 16'hA000 + 16'(i)); end
    end
    step();
    total++; if (load_done !== 1'b0) begin bad++; $display("FAIL clean_load_done_pulse got=%b want=0", load_done); end
  endtask

  task automatic test_ping_pong();
    apply_reset();
    issue_load(4); send_beats(4, 3, 1'b0, 16'h0100);
    issue_load(4); send_beats(4, 3, 1'b0, 16'h0200);
    total++; if (bank_full !== 2'b11) begin bad++; $display("FAIL pp_both_full got=%b want=11", bank_full); end
    total++; if (wq_addr.size() != 8 || wq_addr[4] !== 10'd512 || wq_addr[7] !== 10'd515) begin bad++;
      $display("FAIL pp_bank1_addrs got=n%0d want=n8 with 512..515", wq_addr.size()); end
    issue_load(4);
    step(); step();
    total++; if (busy !== 1'b1 || s_axis_tready !== 1'b0) begin bad++; $display("FAIL pp_wait_bank got=busy%b rdy%b want=busy1 rdy0", busy, s_axis_tready); end
    wq_addr.delete(); wq_data.delete();
    rd_advance = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      total++; if (last_channel !== (k == 3)) begin bad++; $display("FAIL pp_last_channel[%0d] got=%b want=%b", k, last_channel, (k == 3)); end
      step();
      if (k < 3) begin
        total++; if (bram_b_addr !== 10'(k + 1)) begin bad++; $display("FAIL pp_rd_addr[%0d] got=%0d want=%0d", k, bram_b_addr, k + 1); end
      end
    end
    rd_advance = 1'b0;
    total++; if (bank_full !== 2'b10 || bram_b_addr !== 10'd512) begin bad++;
      $display("FAIL pp_release got=full%b addr%0d want=full10 addr512", bank_full, bram_b_addr); end
    total++; if (s_axis_tready !== 1'b0) begin bad++; $display("FAIL pp_still_wait got=%b want=0", s_axis_tready); end
    step();
    total++; if (s_axis_tready !== 1'b1) begin bad++; $display("FAIL pp_enter_load got=%b want=1", s_axis_tready); end
    send_beats(4, 3, 1'b0, 16'h0300);
    total++; if (wq_addr.size() != 4 || wq_addr[0] !== 10'd0 || wq_addr[3] !== 10'd3) begin bad++;
      $display("FAIL pp_third_bank0 got=n%0d want=n4 at 0..3", wq_addr.size()); end
    total++; if (bank_full !== 2'b11) begin bad++; $display("FAIL pp_refilled got=%b want=11", bank_full); end
  endtask

  task automatic test_tlast_fault();
    apply_reset();
    issue_load(5);
    send_beats(3, 2, 1'b0, 16'h0500);
    total++; if (tlast_err !== 1'b1) begin bad++; $display("FAIL tl_early_err got=%b want=1", tlast_err); end
    total++; if (busy !== 1'b1 || load_done !== 1'b0) begin bad++; $display("FAIL tl_not_done_early got=busy%b done%b want=busy1 done0", busy, load_done); end
    send_beats(2, -1, 1'b0, 16'h0503);
    total++; if (load_done !== 1'b1 || wq_addr.size() != 5) begin bad++; $display("FAIL tl_complete got=done%b n%0d want=done1 n5", load_done, wq_addr.size()); end
    total++; if (tlast_err !== 1'b1) begin bad++; $display("FAIL tl_sticky got=%b want=1", tlast_err); end
    step(); step();
    total++; if (tlast_err !== 1'b1) begin bad++; $display("FAIL tl_sticky_idle got=%b want=1", tlast_err); end
    issue_load(2);
    total++; if (tlast_err !== 1'b0) begin bad++; $display("FAIL tl_clear_on_req got=%b want=0", tlast_err); end
    send_beats(2, -1, 1'b0, 16'h0600);
    total++; if (tlast_err !== 1'b1 || load_done !== 1'b1) begin bad++; $display("FAIL tl_missing_last got=err%b done%b want=err1 done1", tlast_err, load_done); end
  endtask

  task automatic test_cfg_err();
    apply_reset();
    issue_load(0);
    total++; if (cfg_err !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL cfg_zero got=err%b busy%b want=err1 busy0", cfg_err, busy); end
    issue_load(1);
    total++; if (cfg_err !== 1'b0 || s_axis_tready !== 1'b1) begin bad++; $display("FAIL cfg_clear got=err%b rdy%b want=err0 rdy1", cfg_err, s_axis_tready); end
    send_beats(1, 0, 1'b0, 16'h0777);
    total++; if (load_done !== 1'b1 || bank_full !== 2'b01 || tlast_err !== 1'b0) begin bad++;
      $display("FAIL cfg_size1 got=done%b full%b err%b want=done1 full01 err0", load_done, bank_full, tlast_err); end
  endtask

  task automatic test_underflow();
    apply_reset();
    issue_load(3); send_beats(3, 2, 1'b0, 16'h0900);
    rd_advance = 1'b1;
    step();
    total++; if (rd_underflow !== 1'b0) begin bad++; $display("FAIL uf_valid_read got=%b want=0", rd_underflow); end
    step(); step();
    rd_advance = 1'b0;
    total++; if (bank_full !== 2'b00 || bram_b_addr !== 10'd512) begin bad++;
      $display("FAIL uf_drained got=full%b addr%0d want=full00 addr512", bank_full, bram_b_addr); end
    rd_advance = 1'b1;
    step();
    rd_advance = 1'b0;
    total++; if (rd_underflow !== 1'b1) begin bad++; $display("FAIL uf_pulse got=%b want=1", rd_underflow); end
    total++; if (bram_b_addr !== 10'd512 || bank_full !== 2'b00) begin bad++;
      $display("FAIL uf_no_change got=addr%0d full%b want=addr512 full00", bram_b_addr, bank_full); end
    step();
    total++; if (rd_underflow !== 1'b0) begin bad++; $display("FAIL uf_pulse_end got=%b want=0", rd_underflow); end
  endtask

  task automatic test_backpressure();
    apply_reset();
    issue_load(16);
    send_beats(16, 15, 1'b1, 16'hB000);
    step(); step();
    total++; if (wq_addr.size() != 16) begin bad++; $display("FAIL bp_write_count got=%0d want=16", wq_addr.size()); end
    for (int i = 0; i < 16 && i < wq_addr.size(); i++) begin
      total++; if (wq_addr[i] !== 10'(i) || wq_data[i] !== 16'hB000 + 16'(i)) begin bad++;
        $display("FAIL bp_write[%0d] got=%0d/%h want=%0d/%h", i, wq_addr[i], wq_data[i], i, 16'hB000 + 16'(i)); end
    end
    total++; if (bank_full !== 2'b01 || tlast_err !== 1'b0) begin bad++; $display("FAIL bp_final got=full%b err%b want=full01 err0", bank_full, tlast_err); end
  endtask

  task automatic test_reset_mid_load();
    apply_reset();
    issue_load(9);
    send_beats(4, -1, 1'b0, 16'hC000);
    s_axis_tvalid = 1'b1;
    Reset = 1'b1;
    #1;
    total++; if ({s_axis_tready, busy, bram_a_en, bram_a_we} !== 4'b0) begin bad++;
      $display("FAIL rml_outputs got=%b want=0000", {s_axis_tready, busy, bram_a_en, bram_a_we}); end
    total++; if ({bank_full, load_done, last_channel, rd_underflow, tlast_err, cfg_err} !== 7'b0) begin bad++;
      $display("FAIL rml_flags got=%b want=0000000", {bank_full, load_done, last_channel, rd_underflow, tlast_err, cfg_err}); end
    step();
    Reset = 1'b0;
    s_axis_tvalid = 1'b0;
    step();
    wq_addr.delete(); wq_data.delete();
    issue_load(9);
    send_beats(9, 8, 1'b0, 16'hD000);
    total++; if (wq_addr.size() != 9 || wq_addr[0] !== 10'd0 || wq_addr[8] !== 10'd8) begin bad++;
      $display("FAIL rml_reload_addrs got=n%0d want=n9 at 0..8", wq_addr.size()); end
    total++; if (bank_full !== 2'b01) begin bad++; $display("FAIL rml_reload_bank got=%b want=01", bank_full); end
  endtask

  initial begin
    test_reset();
    test_clean_load();
    test_ping_pong();
    test_tlast_fault();
    test_cfg_err();
    test_underflow();
    test_backpressure();
    test_reset_mid_load();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/kernel_buffer_ctrl.md
KERNEL_BUFFER_CTRL -- requirements
Module: kernel_buffer_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 16, kernel word width.
REQ-002 SHALL have parameter ADDR_W, default 9, per-bank address width; maximum channel count is 2^ADDR_W.
REQ-003 SHALL have parameter NUM_BANKS, default 2, number of kernel banks; must be a power of two, at least 2.
REQ-004 SHALL have port clk, input, 1, sole clock; all logic on its rising edge.
REQ-005 SHALL have port Reset, input, 1, reset; asynchronous and active-high.
REQ-006 SHALL have port cfg_channel_size, input, ADDR_W+1, channels per kernel; sampled on an accepted load_req.
REQ-007 SHALL have port load_req, input, 1, one-cycle pulse requesting a kernel load.
REQ-008 SHALL have ports s_axis_tdata (input, DATA_W), s_axis_tvalid (input, 1), s_axis_tlast (input, 1) and s_axis_tready (output, 1), the AXI-Stream kernel input.
REQ-009 SHALL have ports bram_a_en, bram_a_we (output, 1 each), bram_a_addr (output, log2(NUM_BANKS)+ADDR_W) and bram_a_din (output, DATA_W), the write port.
REQ-010 SHALL have port rd_advance, input, 1, pulse advancing the read channel.
REQ-011 SHALL have ports bram_b_en (output, 1) and bram_b_addr (output, log2(NUM_BANKS)+ADDR_W), the read port; the bank index forms the MSBs.
REQ-012 SHALL have ports load_done, last_channel and rd_underflow (output, 1 each), one-cycle pulses.
REQ-013 SHALL have ports bank_full (output, NUM_BANKS), tlast_err (output, 1, sticky), cfg_err (output, 1, sticky) and busy (output, 1).

Function
REQ-014 The write FSM SHALL have states IDLE, WAIT_BANK and LOAD.
REQ-015 IDLE: an accepted load_req with cfg_channel_size==0 SHALL set cfg_err and stay in IDLE; otherwise it latches the size and goes to WAIT_BANK if bank_full[wr_bank] is set, else to LOAD.
REQ-016 WAIT_BANK SHALL go to LOAD in the cycle after bank_full[wr_bank] clears.
REQ-017 s_axis_tready SHALL be 1 only in LOAD; a beat transfers on tvalid&&tready.
REQ-018 Each beat SHALL assert bram_a_en and bram_a_we combinationally, with bram_a_din=tdata and bram_a_addr={wr_bank,wr_cnt}; wr_cnt then increments.
REQ-019 The beat with wr_cnt==size-1 SHALL:
- clear wr_cnt to 0;
- set bank_full[wr_bank];
- advance wr_bank modulo NUM_BANKS;
- pulse load_done in the following cycle;
- return the FSM to IDLE.
REQ-020 tlast SHALL be checked on every beat; tlast asserted on a non-final beat, or deasserted on the final beat, SHALL set tlast_err.
REQ-021 The beat count SHALL NOT change on a tlast mismatch; the load always completes at size beats.
REQ-022 tlast_err and cfg_err SHALL clear only on the next accepted load_req.
REQ-023 load_req SHALL be ignored outside IDLE.
REQ-024 busy SHALL be 1 whenever the FSM is not in IDLE.
REQ-025 bram_b_en SHALL be held at 1; bram_b_addr={rd_bank,rd_cnt} SHALL be registered.
REQ-026 rd_advance while bank_full[rd_bank]==1 SHALL increment rd_cnt, with the new address visible one cycle later.
REQ-027 If rd_cnt==size_rd-1 on that rd_advance, the block SHALL:
- wrap rd_cnt to 0;
- pulse last_channel in the same cycle (combinational);
- clear bank_full[rd_bank];
- advance rd_bank modulo NUM_BANKS.
REQ-028 size_rd SHALL be the size latched for the bank being read, stored per bank.
REQ-029 rd_advance while bank_full[rd_bank]==0 SHALL pulse rd_underflow and change no state.
REQ-030 When a final write beat and a final read occur in the same cycle (necessarily different banks), both bank_full updates SHALL apply.
REQ-031 bank_full SHALL never be cleared by the write side or set by the read side.

Reset
REQ-032 While Reset is asserted, the following SHALL be 0: all counters, wr_bank, rd_bank, bank_full, every pulse output, tlast_err, cfg_err, busy, s_axis_tready, bram_a_en and bram_a_we; the FSM SHALL be in IDLE.
REQ-033 Reset asserted mid-load SHALL abandon the load; partially written data SHALL be treated as invalid.
REQ-034 After Reset deasserts, the first load SHALL go to bank 0.

Structure
REQ-035 The shared package SHALL hold the FSM state encoding and the default DATA_W, ADDR_W and NUM_BANKS constants.
REQ-036 The read address logic (rd_cnt, rd_bank, per-bank sizes) SHALL be one sub-module, kernel_rd_addr_gen.

Verification
REQ-037 The bench SHALL cover a clean load: size=9, 9 beats with tlast on beat 9 -> writes to addresses 0..8, load_done 1 cycle after beat 9, bank_full=01, tready=0.
REQ-038 The bench SHALL cover ping-pong: two loads of size 4, then a third load_req -> FSM in WAIT_BANK; 4 rd_advance -> last_channel on the 4th, bank_full[0] clears, third load enters LOAD to bank 0 the next cycle.
REQ-039 The bench SHALL cover tlast faults: tlast on beat 3 of 5 -> tlast_err=1 and load completes after beat 5; next load_req -> tlast_err=0.
REQ-040 The bench SHALL cover underflow: rd_advance with bank_full=00 -> rd_underflow pulse, bram_b_addr unchanged.
REQ-041 The bench SHALL cover backpressure: tvalid toggled every cycle with size=16 -> exactly 16 writes, correct addresses, no gaps in the address sequence.
REQ-042 The bench SHALL cover reset mid-load: Reset asserted at beat 5 of 9 -> all outputs 0 immediately; a new load writes bank 0 from address 0.
